// File: rtl/imem_burst_ctrl.sv
// Instruction-memory backing store with a fixed-latency burst-read port for the I-cache miss path.
// Contents survive reset; a preload port writes words at any time outside reset.
module imem_burst_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BLOCK_SIZE     = 4,
  parameter int MEM_DEPTH      = 1024,
  parameter int ACCESS_LATENCY = 3,
  parameter int BEAT_GAP       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MEM_READ_REQ,
  input  logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
  output logic                  MEM_BUSYWAIT,
  output logic [DATA_WIDTH-1:0] MEM_READDATA,
  output logic                  MEM_READDATA_VALID,
  input  logic                  LOAD_EN,
  input  logic [ADDR_WIDTH-1:0] LOAD_ADDR,
  input  logic [DATA_WIDTH-1:0] LOAD_DATA
);

  localparam int OFF   = $clog2(BLOCK_SIZE);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int LAT_W = (ACCESS_LATENCY > 1) ? $clog2(ACCESS_LATENCY) : 1;
  localparam int GAP_W = (BEAT_GAP > 0) ? $clog2(BEAT_GAP + 1) : 1;

  localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'((ACCESS_LATENCY > 1) ? ACCESS_LATENCY - 2 : 0);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(BEAT_GAP);
  localparam logic [OFF-1:0]   BEAT_LAST  = OFF'(BLOCK_SIZE - 1);
  localparam logic [IDX_W-1:0] OFF_MASK   = IDX_W'(BLOCK_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATENCY,
    S_BURST
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_base;
  logic [LAT_W-1:0]      r_lat_cnt;
  logic [OFF-1:0]        r_beat_cnt;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic                  r_busy;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  state_t                w_state_next;
  logic [IDX_W-1:0]      w_base_next;
  logic [LAT_W-1:0]      w_lat_cnt_next;
  logic [OFF-1:0]        w_beat_cnt_next;
  logic [GAP_W-1:0]      w_gap_cnt_next;
  logic                  w_busy_next;
  logic                  w_issue;
  logic                  w_last;
  logic [IDX_W-1:0]      w_rd_idx;
  logic                  w_unused;

  // Upper address bits alias onto the array; block offset bits are discarded.
  assign w_unused = ^{MEM_ADDRESS, LOAD_ADDR};
  assign w_rd_idx = r_base + IDX_W'(r_beat_cnt);

  always_comb begin
    w_state_next    = r_state;
    w_base_next     = r_base;
    w_lat_cnt_next  = r_lat_cnt;
    w_beat_cnt_next = r_beat_cnt;
    w_gap_cnt_next  = r_gap_cnt;
    w_issue         = 1'b0;
    w_last          = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (MEM_READ_REQ && !r_busy) begin
          w_base_next     = MEM_ADDRESS[IDX_W-1:0] & ~OFF_MASK;
          w_lat_cnt_next  = '0;
          w_beat_cnt_next = '0;
          w_gap_cnt_next  = '0;
          w_state_next    = (ACCESS_LATENCY == 1) ? S_BURST : S_LATENCY;
        end
      end
      S_LATENCY: begin
        w_lat_cnt_next = r_lat_cnt + 1'b1;
        if (r_lat_cnt == LAT_LAST) begin
          w_state_next = S_BURST;
        end
      end
      S_BURST: begin
        if (r_gap_cnt != '0) begin
          w_gap_cnt_next = r_gap_cnt - 1'b1;
        end else begin
          w_issue        = 1'b1;
          w_gap_cnt_next = GAP_RELOAD;
          if (r_beat_cnt == BEAT_LAST) begin
            w_last       = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_beat_cnt_next = r_beat_cnt + 1'b1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    // Busy stays up through the cycle that shows the final beat.
    w_busy_next = (w_state_next != S_IDLE) || w_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_lat_cnt  <= '0;
      r_beat_cnt <= '0;
      r_gap_cnt  <= '0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_base     <= w_base_next;
      r_lat_cnt  <= w_lat_cnt_next;
      r_beat_cnt <= w_beat_cnt_next;
      r_gap_cnt  <= w_gap_cnt_next;
      r_busy     <= w_busy_next;
      r_valid    <= w_issue;
      if (w_issue) begin
        r_rdata <= r_mem[w_rd_idx];
      end
    end
  end

  // Read-before-write: a beat reading the index being preloaded sees the old word.
  always_ff @(posedge clk) begin
    if (LOAD_EN && !reset) begin
      r_mem[LOAD_ADDR[IDX_W-1:0]] <= LOAD_DATA;
    end
  end

  assign MEM_BUSYWAIT       = r_busy;
  assign MEM_READDATA_VALID = r_valid;
  assign MEM_READDATA       = r_rdata;

endmodule

// File: tb/tb_imem_burst_ctrl.sv
// Bench for imem_burst_ctrl: a default instance and a BEAT_GAP=2 instance share one stimulus stream
// and are checked every cycle against a timetable model, plus hand-computed literal points.
module tb_imem_burst_ctrl;

  localparam int L     = 3;
  localparam int B     = 4;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [31:0] addr;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  logic [1:0]       o_busy;
  logic [1:0]       o_valid;
  logic [1:0][31:0] o_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_burst_ctrl dut0 (
    .clk(clk), .reset(reset), .MEM_READ_REQ(req), .MEM_ADDRESS(addr),
    .MEM_BUSYWAIT(o_busy[0]), .MEM_READDATA(o_data[0]), .MEM_READDATA_VALID(o_valid[0]),
    .LOAD_EN(load_en), .LOAD_ADDR(load_addr), .LOAD_DATA(load_data)
  );

  imem_burst_ctrl #(.BEAT_GAP(2)) dut1 (
    .clk(clk), .reset(reset), .MEM_READ_REQ(req), .MEM_ADDRESS(addr),
    .MEM_BUSYWAIT(o_busy[1]), .MEM_READDATA(o_data[1]), .MEM_READDATA_VALID(o_valid[1]),
    .LOAD_EN(load_en), .LOAD_ADDR(load_addr), .LOAD_DATA(load_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  // Timetable model: an accepted request at cycle t yields beat k at t+L+1+k*(gap+1)
  // and busy over t+1 .. t+L+B+(B-1)*gap.
  int               cyc = 0;
  bit               act [2];
  int               t_acc [2];
  int               base [2];
  logic [1:0]       e_busy  = '0;
  logic [1:0]       e_valid = '0;
  logic [1:0][31:0] e_data  = '0;
  logic [31:0]      shadow [DEPTH];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic cur_busy;
      int   g;
      cur_busy = e_busy[i];
      g = gap_of(i);
      if (reset) begin
        act[i]     = 1'b0;
        e_busy[i]  = 1'b0;
        e_valid[i] = 1'b0;
        e_data[i]  = '0;
      end else begin
        e_valid[i] = 1'b0;
        e_busy[i]  = 1'b0;
        if (act[i]) begin
          for (int k = 0; k < B; k++) begin
            if (cyc + 1 == t_acc[i] + L + 1 + k * (g + 1)) begin
              e_valid[i] = 1'b1;
              e_data[i]  = shadow[(base[i] + k) % DEPTH];
            end
          end
          e_busy[i] = (cyc + 1 < t_acc[i] + 1 + L + B + (B - 1) * g);
          if (!e_busy[i]) act[i] = 1'b0;
        end
        if (req && !cur_busy) begin
          act[i]    = 1'b1;
          t_acc[i]  = cyc;
          base[i]   = ((addr % DEPTH) / B) * B;
          e_busy[i] = 1'b1;
        end
      end
    end
    if (!reset && load_en) shadow[load_addr % DEPTH] = load_data;
    cyc++;
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("busy%0d@%0d", i, cyc), 32'(o_busy[i]), 32'(e_busy[i]));
        check($sformatf("valid%0d@%0d", i, cyc), 32'(o_valid[i]), 32'(e_valid[i]));
        check($sformatf("data%0d@%0d", i, cyc), o_data[i], e_data[i]);
      end
    end
  end

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy != 2'b00 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(o_busy), 32'h0);
    repeat (2) @(negedge clk);
  endtask

  logic [1:0]  sb [0:40];
  logic [1:0]  sv [0:40];
  logic [31:0] sd0 [0:40];
  logic [31:0] sd1 [0:40];
  logic [31:0] q0 [$];
  int          nv0, nv1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req = 1'b0; addr = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_data0", o_data[0], 32'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) load(32'h100 + i, 32'hA000_0000 + i);
    for (int i = 0; i < 4; i++) load(32'h3FC + i, 32'hB000_03FC + i);
    for (int i = 0; i < 4; i++) load(32'h000 + i, 32'hC000_0000 + i);
    for (int i = 0; i < 4; i++) load(32'h200 + i, 32'hE000_0200 + i);

    // Basic burst, address offset bits ignored
    $display("txn: burst addr=0x102 (both gaps)");
    req = 1'b1; addr = 32'h102;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) req = 1'b0;
      sb[k] = o_busy; sv[k] = o_valid; sd0[k] = o_data[0]; sd1[k] = o_data[1];
    end
    check("g0_busy_T1", 32'(sb[1][0]), 32'h1);
    check("g0_valid_T3", 32'(sv[3][0]), 32'h0);
    for (int k = 4; k <= 7; k++) begin
      check($sformatf("g0_valid_T%0d", k), 32'(sv[k][0]), 32'h1);
      check($sformatf("g0_data_T%0d", k), sd0[k], 32'hA000_0000 + 32'(k - 4));
    end
    check("g0_busy_T7", 32'(sb[7][0]), 32'h1);
    check("g0_busy_T8", 32'(sb[8][0]), 32'h0);
    check("g0_valid_T8", 32'(sv[8][0]), 32'h0);
    check("g2_valid_T4", 32'(sv[4][1]), 32'h1);
    check("g2_valid_T5", 32'(sv[5][1]), 32'h0);
    check("g2_hold_T6", sd1[6], 32'hA000_0000);
    check("g2_valid_T7", 32'(sv[7][1]), 32'h1);
    check("g2_valid_T10", 32'(sv[10][1]), 32'h1);
    check("g2_valid_T13", 32'(sv[13][1]), 32'h1);
    check("g2_data_T13", sd1[13], 32'hA000_0003);
    check("g2_busy_T13", 32'(sb[13][1]), 32'h1);
    check("g2_busy_T14", 32'(sb[14][1]), 32'h0);
    wait_idle();

    // Back-to-back with REQ held high, wrap at array top
    $display("txn: held req addr=0x3FC then 0x000");
    req = 1'b1; addr = 32'h3FC; nv0 = 0; nv1 = 0; q0.delete();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) addr = 32'h000;
      if (k == 15) req = 1'b0;
      if (k == 8) check("b2b_busy_T8", 32'(o_busy[0]), 32'h0);
      if (k == 9) check("b2b_busy_T9", 32'(o_busy[0]), 32'h1);
      if (o_valid[0]) begin nv0++; q0.push_back(o_data[0]); end
      if (o_valid[1]) nv1++;
    end
    check("b2b_count0", 32'(nv0), 32'd8);
    check("b2b_count1", 32'(nv1), 32'd8);
    for (int i = 0; i < 8 && i < q0.size(); i++)
      check($sformatf("b2b_word%0d", i), q0[i], (i < 4) ? 32'hB000_03FC + 32'(i) : 32'hC000_0000 + 32'(i - 4));
    wait_idle();

    // Request during an active burst is dropped
    $display("txn: burst addr=0x100 with stray req addr=0x200");
    req = 1'b1; addr = 32'h100; nv0 = 0; nv1 = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) req = 1'b0;
      if (k == 2) begin req = 1'b1; addr = 32'h200; end
      if (k == 4) req = 1'b0;
      if (k == 5) check("ign_data_T5", o_data[0], 32'hA000_0001);
      nv0 += int'(o_valid[0]);
      nv1 += int'(o_valid[1]);
    end
    check("ign_count0", 32'(nv0), 32'd4);
    check("ign_count1", 32'(nv1), 32'd4);
    wait_idle();

    // Preload colliding with the beat-1 read
    $display("txn: burst addr=0x100 with preload 0x101 during beat 1 read");
    req = 1'b1; addr = 32'h100;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) req = 1'b0;
      if (k == 4) begin load_en = 1'b1; load_addr = 32'h101; load_data = 32'hDEAD_BEEF; end
      if (k == 5) begin
        load_en = 1'b0;
        check("coll_old_T5", o_data[0], 32'hA000_0001);
      end
      if (k == 7) check("coll_g2_new_T7", o_data[1], 32'hDEAD_BEEF);
    end
    wait_idle();
    $display("txn: burst addr=0x100 after preload");
    req = 1'b1; addr = 32'h100;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) req = 1'b0;
      if (k == 5) check("coll_new_T5", o_data[0], 32'hDEAD_BEEF);
    end
    wait_idle();

    // Reset mid-burst; request and load in the reset cycle are ignored
    $display("txn: burst addr=0x100 abandoned by reset");
    req = 1'b1; addr = 32'h100; nv0 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) req = 1'b0;
      if (k == 5) begin
        reset = 1'b1; req = 1'b1;
        load_en = 1'b1; load_addr = 32'h100; load_data = 32'h5555_5555;
      end
      if (k == 6) begin
        reset = 1'b0; req = 1'b0; load_en = 1'b0;
        check("rst_mid_busy", 32'(o_busy), 32'h0);
        check("rst_mid_valid", 32'(o_valid), 32'h0);
        check("rst_mid_data0", o_data[0], 32'h0);
        check("rst_mid_data1", o_data[1], 32'h0);
      end
      if (k >= 6) nv0 += int'(o_valid[0]);
    end
    check("rst_no_beats", 32'(nv0), 32'd0);
    wait_idle();
    $display("txn: burst addr=0x100 after reset");
    req = 1'b1; addr = 32'h100;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) req = 1'b0;
      if (k == 4) check("post_rst_T4", o_data[0], 32'hA000_0000);
      if (k == 5) check("post_rst_T5", o_data[0], 32'hDEAD_BEEF);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
